// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and data width.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int OS_TICKS = 16;
   localparam int DATA_W   = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO. Extra pointer MSB distinguishes full from empty.
// A push into an empty FIFO becomes visible to the reader one cycle later.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a 16x-oversampled frame FSM.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s); otherwise frames are 8N1/8N2.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line high, waiting for a byte in the FIFO; ticks ignored
// START  | start bit (TX=0) for one bit period
// DATA   | 8 data bits, LSB first, shift register drives TX
// PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS bit periods of TX=1, then next frame or IDLE
module uart_tx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_tick,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [7:0]  tx_data,
   output logic        tx_busy,
   output logic        TX
);

   localparam int TICK_W = $clog2(OS_TICKS);
   localparam int BIT_W  = $clog2(DATA_W);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t        state, state_nxt;
   logic [TICK_W-1:0]  tick_cnt, tick_nxt;
   logic [BIT_W-1:0]   bit_idx, bit_nxt;
   logic               stop_cnt, stop_nxt;
   logic [DATA_W-1:0]  shift, shift_nxt;
   logic               tx_q, tx_nxt;
   logic               load;
   logic               bit_end;
   logic [DATA_W-1:0]  fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
`ifdef UART_TX_PARITY_EN
   logic               par_q, par_nxt;
`endif

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid & ~fifo_full),
      .pop   (load),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tx_ready = ~fifo_full;
   assign tx_busy  = (state != IDLE) | ~fifo_empty;
   assign TX       = tx_q;
   assign bit_end  = tx_tick && (tick_cnt == TICK_W'(OS_TICKS - 1));

   // Next-state, counters, shifter and the registered line value.
   always_comb begin
      state_nxt = state;
      tick_nxt  = tick_cnt;
      bit_nxt   = bit_idx;
      stop_nxt  = stop_cnt;
      shift_nxt = shift;
      load      = 1'b0;
      tx_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par_q;
`endif

      if (state != IDLE && tx_tick) tick_nxt = tick_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = {1'b0, shift[DATA_W-1:1]};
               bit_nxt   = bit_idx + 1'b1;
               if (bit_idx == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (stop_cnt == LAST_STOP) begin
                  stop_nxt = 1'b0;
                  if (!fifo_empty) load = 1'b1;
                  else             state_nxt = IDLE;
               end else begin
                  stop_nxt = stop_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Loading starts the next frame on this edge, so no idle gap between frames.
      if (load) begin
         state_nxt = START;
         shift_nxt = fifo_dout;
         tick_nxt  = '0;
         bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
         par_nxt   = even_parity(fifo_dout);
`endif
      end

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame and idles the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         shift    <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_nxt;
         bit_idx  <= bit_nxt;
         stop_cnt <= stop_nxt;
         shift    <= shift_nxt;
         tx_q     <= tx_nxt;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_nxt;
`endif
      end
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; a power of two, 2..16.
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits; 1 or 2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_tick  input  1  16x-oversample baud strobe, one clk wide.
REQ-006 SHALL have port tx_valid  input  1  user byte offered.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port tx_data  input  8  user byte, LSB transmitted first.
REQ-009 SHALL have port tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL have port TX  output  1  serial line, idle high, registered.

Function
REQ-011 SHALL accept a byte into the FIFO on any clk edge where tx_valid & tx_ready; tx_ready = FIFO not full.
REQ-012 SHALL hold tx_ready low when the FIFO is full, even if a pop occurs in the same cycle.
REQ-013 SHALL make a byte pushed into an empty FIFO poppable no earlier than the following cycle.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL, in IDLE with the FIFO non-empty, pop the head byte into a shift register, clear the tick counter and enter START on the same edge.
REQ-016 SHALL drive TX=0 in START, TX=shift[0] in DATA, TX=parity in PARITY and TX=1 in IDLE and STOP, all registered.
REQ-017 SHALL increment a 4-bit tick counter on each tx_tick; 16 ticks (counter wraps 15 to 0) end one bit period.
REQ-018 SHALL leave START for DATA after 16 ticks.
REQ-019 SHALL shift the data right and increment a 3-bit bit index after each 16 ticks in DATA.
REQ-020 SHALL leave DATA after bit 7 completes, going to PARITY when parity is enabled and to STOP otherwise.
REQ-021 SHALL leave PARITY for STOP after 16 ticks.
REQ-022 SHALL remain in STOP for STOP_BITS x 16 ticks, then go to START with a pop if the FIFO is non-empty (no idle gap) or to IDLE otherwise.
REQ-023 SHALL ignore tx_tick in IDLE, so the first start bit lasts exactly 16 ticks after entry.
REQ-024 SHALL drive tx_busy = (state != IDLE) | FIFO non-empty.
REQ-025 SHALL tolerate tx_tick high on every clk, giving a frame of 160 clk with parity disabled and STOP_BITS=1.

Reset
REQ-026 SHALL, on an rst-high edge, set TX=1, state IDLE, counters 0, FIFO empty, tx_ready=1 and tx_busy=0.
REQ-027 SHALL abort any frame in progress on reset mid-operation and discard the buffered bytes; rst has priority over tx_valid.

Configuration
REQ-028 SHALL, with UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits, computed when the byte is loaded) between DATA and STOP.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely, so the frame is 8N1 or 8N2.

Structure
REQ-030 SHALL place the FSM state enum, the OS_TICKS=16 constant and DATA_W=8 in shared package uart_pkg, also used by the receiver.
REQ-031 SHALL implement the FIFO as sub-module uart_tx_fifo (parameter DEPTH; push/pop/full/empty), with the FSM and shifter in uart_tx.

Verification
REQ-032 SHALL verify: tx_tick every clk, push 0xA5 -> TX low for 16 clk, then bits 1,0,1,0,0,1,0,1 (16 clk each), then high; tx_busy low 160 clk after the pop.
REQ-033 SHALL verify: push 0x00, 0xFF, 0x55 back-to-back -> three contiguous frames, each stop bit followed directly by the next start bit, with no idle cycles between frames.
REQ-034 SHALL verify: FIFO_DEPTH=4 with the line busy, push 6 bytes -> tx_ready drops after 5 accepts (4 FIFO + 1 in shifter); stalled bytes are sent after tx_ready rises.
REQ-035 SHALL verify: with UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame length 176 ticks.
REQ-036 SHALL verify: assert rst during DATA bit 3 -> TX=1 next edge, tx_busy=0; next pushed byte 0x3C is sent as a clean frame.
REQ-037 SHALL verify: tx_tick every 8th clk, STOP_BITS=2, loopback to the existing receiver -> received bytes match 0x12, 0x34, 0xEF in order.
